// File: rtl/pixel_scanout_pkg.sv
// Shared scanout types and default VGA 640x480 timing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pixel_scanout_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } scanout_state_e;

    // Default 640x480 timing, in pixel ticks (horizontal) and lines (vertical)
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Counter width that can hold 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_scanout_if.sv
// Pixel-memory read port plus raster video outputs of the scanout block.
// Latency: memData is valid exactly 1 clk after memRe.
// Backpressure: none; reads are never stalled.
interface pixel_scanout_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] memAddr;
    logic              memRe;
    logic [DATA_W-1:0] memData;
    logic [DATA_W-1:0] pixOut;
    logic              hsync;
    logic              vsync;
    logic              blank;
    logic              frameStart;

    // Scanout side: drives the read port and the video outputs
    modport master (
        output memAddr, memRe, pixOut, hsync, vsync, blank, frameStart,
        input  memData
    );

    // Memory/display side
    modport slave (
        input  memAddr, memRe, pixOut, hsync, vsync, blank, frameStart,
        output memData
    );
endinterface

// File: rtl/pixel_scanout_raster_counter.sv
// raster_counter: pixel-tick divider, hCnt/vCnt raster position and sync/visible decode.
// Latency: decode outputs are combinational from the current counter values.
// Backpressure: none; counters free-run while run=1 and sit at zero otherwise.
module raster_counter
    import pixel_scanout_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int PIX_DIV  = 2,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = cnt_w(H_TOTAL),
    localparam int VW      = cnt_w(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic          tick,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          visible,
    output logic          hs_n,
    output logic          vs_n,
    output logic          frame_end
);
    localparam int DW = cnt_w(PIX_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt;

    // Divider and raster position; everything held at zero while not running
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Tick and position decode for the current raster position
    always_comb begin
        tick      = run && (div_cnt == DIV_LAST);
        visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_n      = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_n      = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        frame_end = tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

endmodule

// File: rtl/pixel_scanout.sv
// pixel_scanout: reads pixel memory through its read port and streams it as a VGA raster.
// Latency: 2 clk from the tick presenting (hCnt,vCnt) to pixOut/hsync/vsync/blank/frameStart.
// Backpressure: none; one fire-and-forget read per displayed image pixel tick.
// Build option PDA_SCANOUT_UPSCALE_EN: each image pixel covers a 2x2 screen block.
module pixel_scanout
    import pixel_scanout_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 16,
    parameter int PIX_DIV  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    output logic            running,
    pixel_scanout_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = cnt_w(H_TOTAL);
    localparam int VW      = cnt_w(V_TOTAL);
    // Bits of x in the address; the image width is a power of two
    localparam int XB      = $clog2(IMG_W);

    scanout_state_e state;

    logic          tick;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          visible;
    logic          hs_n;
    logic          vs_n;
    logic          frame_end;

    logic [31:0]       x_img;
    logic [31:0]       y_img;
    logic              in_img;
    logic [ADDR_W-1:0] rd_addr;

    // Stage 1: sideband of the tick whose read is in flight
    logic s1_vld;
    logic s1_img;
    logic s1_hs_n;
    logic s1_vs_n;
    logic s1_blank;
    logic s1_first;

    // Stage 2: registered video outputs
    logic [DATA_W-1:0] pix_q;
    logic              hs_q;
    logic              vs_q;
    logic              blank_q;
    logic              fs_q;

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .PIX_DIV  (PIX_DIV)
    ) u_raster (
        .clk       (clk),
        .reset     (reset),
        .run       (running),
        .tick      (tick),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .visible   (visible),
        .hs_n      (hs_n),
        .vs_n      (vs_n),
        .frame_end (frame_end)
    );

    // Run control: leaving RUN lets the current frame finish before going idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= STOPPING;
                    end
                end
                STOPPING: begin
                    if (enable) begin
                        state <= RUN;
                    end else if (frame_end) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Screen position to image coordinates
`ifdef PDA_SCANOUT_UPSCALE_EN
    assign x_img = 32'(h_cnt >> 1);
    assign y_img = 32'(v_cnt >> 1);
`else
    assign x_img = 32'(h_cnt);
    assign y_img = 32'(v_cnt);
`endif

    // Image-region test and read address for the current position
    always_comb begin
        in_img  = visible && (x_img < IMG_W) && (y_img < IMG_H);
        rd_addr = ADDR_W'(((y_img & (IMG_H - 1)) << XB) | (x_img & (IMG_W - 1)));
    end

    assign bus.memRe   = tick && in_img;
    assign bus.memAddr = rd_addr;

    // Stage 1: snapshot position sideband on each tick, alongside the read
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld   <= 1'b0;
            s1_img   <= 1'b0;
            s1_hs_n  <= 1'b1;
            s1_vs_n  <= 1'b1;
            s1_blank <= 1'b1;
            s1_first <= 1'b0;
        end else begin
            s1_vld <= tick;
            if (tick) begin
                s1_img   <= in_img;
                s1_hs_n  <= hs_n;
                s1_vs_n  <= vs_n;
                s1_blank <= !visible;
                s1_first <= (h_cnt == '0) && (v_cnt == '0);
            end
        end
    end

    // Stage 2: capture read data and register all video outputs together
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            fs_q <= s1_vld && s1_first;
            if (s1_vld) begin
                pix_q   <= s1_img ? bus.memData : '0;
                hs_q    <= s1_hs_n;
                vs_q    <= s1_vs_n;
                blank_q <= s1_blank;
            end
        end
    end

    assign bus.pixOut     = pix_q;
    assign bus.hsync      = hs_q;
    assign bus.vsync      = vs_q;
    assign bus.blank      = blank_q;
    assign bus.frameStart = fs_q;

endmodule
